// File: rtl/error_report_packer.sv
// rtl/error_report_packer.sv - captures flushed error records and emits them as one framed byte packet
module error_report_packer #(
  parameter int         DEPTH  = 8,
  parameter logic [7:0] HEADER = 8'hE5
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic [22:0] in_error_reg,
  input  logic        in_valid_error_reg,
  input  logic        in_start_flush_error_reg,
  output logic [7:0]  out_byte,
  output logic        out_byte_valid,
  input  logic        in_byte_ready,
  output logic        out_busy,
  output logic        out_overrun
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_CNT     = 3'd3;
  localparam logic [2:0] S_PAY     = 3'd4;
  localparam logic [2:0] S_CSUM    = 3'd5;

  logic [2:0]    state, state_next;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    csum;
  logic [IW-1:0] rd_idx;
  logic [1:0]    sel;
  logic [22:0]   buffer [DEPTH];

  logic          accept;
  logic          last_rec;
  logic          full;
  logic          tx_state;
  logic [7:0]    sum_next;
  logic [7:0]    byte_next;
  logic [22:0]   rec_cur, rec_next;

  assign accept   = out_byte_valid & in_byte_ready;
  assign full     = (count == CW'(DEPTH));
  assign tx_state = (state == S_HDR) || (state == S_CNT) || (state == S_PAY) || (state == S_CSUM);
  assign sum_next = csum + out_byte;
  assign last_rec = (({1'b0, rd_idx} + CW'(1)) == count);
  assign rec_cur  = buffer[rd_idx];
  assign rec_next = buffer[rd_idx + IW'(1)];

  // Next state and the byte to register alongside it, so out_byte is valid the cycle the state is entered.
  always_comb begin
    state_next = state;
    byte_next  = out_byte;
    case (state)
      S_IDLE: begin
        byte_next = 8'h00;
        if (in_start_flush_error_reg) state_next = S_COLLECT;
      end
      S_COLLECT: begin
        byte_next = 8'h00;
        if (!in_start_flush_error_reg) begin
          state_next = S_HDR;
          byte_next  = HEADER;
        end
      end
      S_HDR: begin
        if (accept) begin
          state_next = S_CNT;
          byte_next  = {overflow, 7'(count)};
        end
      end
      S_CNT: begin
        if (accept) begin
          if (count != '0) begin
            state_next = S_PAY;
            byte_next  = {1'b0, buffer[0][22:16]};
          end else begin
            state_next = S_CSUM;
            byte_next  = sum_next;
          end
        end
      end
      S_PAY: begin
        if (accept) begin
          if (sel == 2'd2) begin
            if (last_rec) begin
              state_next = S_CSUM;
              byte_next  = sum_next;
            end else begin
              byte_next = {1'b0, rec_next[22:16]};
            end
          end else if (sel == 2'd0) begin
            byte_next = rec_cur[15:8];
          end else begin
            byte_next = rec_cur[7:0];
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_next = S_IDLE;
          byte_next  = 8'h00;
        end
      end
      default: begin
        state_next = S_IDLE;
        byte_next  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state          <= S_IDLE;
      count          <= '0;
      overflow       <= 1'b0;
      csum           <= 8'h00;
      rd_idx         <= '0;
      sel            <= 2'd0;
      out_byte       <= 8'h00;
      out_byte_valid <= 1'b0;
      out_busy       <= 1'b0;
      out_overrun    <= 1'b0;
    end else begin
      state          <= state_next;
      out_byte       <= byte_next;
      out_byte_valid <= (state_next == S_HDR) || (state_next == S_CNT) ||
                        (state_next == S_PAY) || (state_next == S_CSUM);
      out_busy       <= (state_next != S_IDLE);
      out_overrun    <= in_valid_error_reg & tx_state;
      case (state)
        S_IDLE: begin
          if (in_start_flush_error_reg) begin
            count    <= in_valid_error_reg ? CW'(1) : '0;
            overflow <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (in_valid_error_reg) begin
            if (full) overflow <= 1'b1;
            else      count    <= count + CW'(1);
          end
          if (!in_start_flush_error_reg) csum <= 8'h00;
        end
        S_CNT: begin
          if (accept) begin
            csum   <= sum_next;
            rd_idx <= '0;
            sel    <= 2'd0;
          end
        end
        S_PAY: begin
          if (accept) begin
            csum <= sum_next;
            if (sel == 2'd2) begin
              sel    <= 2'd0;
              rd_idx <= rd_idx + IW'(1);
            end else begin
              sel <= sel + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Record storage carries no reset; count decides which entries are meaningful.
  always_ff @(posedge sysClk) begin
    if (!reset) begin
      if (state == S_IDLE && in_start_flush_error_reg && in_valid_error_reg)
        buffer[0] <= in_error_reg;
      else if (state == S_COLLECT && in_valid_error_reg && !full)
        buffer[count[IW-1:0]] <= in_error_reg;
    end
  end

endmodule

// File: tb/tb_error_report_packer.sv
// tb/tb_error_report_packer.sv - scoreboard bench for error_report_packer
module tb_error_report_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] rec_in;
  logic        rec_valid;
  logic        flush;
  logic [7:0]  out_byte;
  logic        out_byte_valid;
  logic        ready;
  logic        out_busy;
  logic        out_overrun;

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  bit timed_out;

  logic [22:0] recs_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];

  error_report_packer #(.DEPTH(8), .HEADER(8'hE5)) dut (
    .sysClk(clk),
    .reset(reset),
    .in_error_reg(rec_in),
    .in_valid_error_reg(rec_valid),
    .in_start_flush_error_reg(flush),
    .out_byte(out_byte),
    .out_byte_valid(out_byte_valid),
    .in_byte_ready(ready),
    .out_busy(out_busy),
    .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_byte_valid && ready) obs_q.push_back(out_byte);
    if (!reset && out_overrun) ovr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: header, {overflow,count}, 3 bytes per kept record, sum of all but header.
  task automatic build_exp();
    int n;
    logic [7:0] s;
    logic [7:0] b;
    n = (recs_q.size() > 8) ? 8 : recs_q.size();
    exp_q.push_back(8'hE5);
    b = {(recs_q.size() > 8) ? 1'b1 : 1'b0, 7'(n)};
    exp_q.push_back(b);
    s = b;
    for (int i = 0; i < n; i++) begin
      b = {1'b0, recs_q[i][22:16]}; exp_q.push_back(b); s = s + b;
      b = recs_q[i][15:8];          exp_q.push_back(b); s = s + b;
      b = recs_q[i][7:0];           exp_q.push_back(b); s = s + b;
    end
    exp_q.push_back(s);
  endtask

  task automatic send_window(input int hold);
    flush = 1'b1;
    foreach (recs_q[i]) begin
      rec_in = recs_q[i];
      rec_valid = 1'b1;
      tick();
    end
    rec_valid = 1'b0;
    repeat (hold) tick();
    flush = 1'b0;
    build_exp();
    tick();
  endtask

  task automatic wait_done();
    int g = 0;
    while (out_busy && g < 300) begin
      tick();
      g++;
    end
    timed_out = out_busy;
  endtask

  task automatic start_scenario();
    recs_q.delete();
    exp_q.delete();
    obs_q.delete();
    ovr_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; rec_valid = 1'b0; rec_in = '0; ready = 1'b1;
    repeat (3) tick();
    tests++; if (out_byte !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h want 00", out_byte); end
    tests++; if (out_byte_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_byte_valid); end
    tests++; if (out_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", out_busy); end
    tests++; if (out_overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", out_overrun); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idle_ignore();
    start_scenario();
    rec_in = 23'h00ABCD; rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    tick();
    tests++; if (ovr_cnt !== 0 || out_busy !== 1'b0) begin fails++; $display("FAIL idle_ignore: overruns %0d busy %b want 0 0", ovr_cnt, out_busy); end
  endtask

  task automatic test_single();
    int n = 0;
    start_scenario();
    recs_q.push_back(23'h012345);
    send_window(2);
    tests++; if (out_byte_valid !== 1'b1 || out_byte !== 8'hE5) begin fails++; $display("FAIL single_hdr_latency: got valid %b byte %h want 1 e5", out_byte_valid, out_byte); end
    while (out_byte_valid && n < 50) begin tick(); n++; end
    tests++; if (n !== 6) begin fails++; $display("FAIL single_frame_cycles: got %0d want 6", n); end
    tests++; if (out_busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", out_busy); end
    tests++; if (exp_q.size() != 6 || exp_q[5] !== 8'h6A) begin fails++; $display("FAIL single_model_csum: got %0d bytes want 6 with csum 6a", exp_q.size()); end
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty();
    start_scenario();
    send_window(2);
    wait_done();
    tests++; if (timed_out) begin fails++; $display("FAIL empty_timeout: busy %b want 0", out_busy); end
    tests++;
    if (obs_q.size() != 3) begin fails++; $display("FAIL empty_len: got %0d want 3", obs_q.size()); end
    else begin
      tests++; if (obs_q[0] !== 8'hE5 || obs_q[1] !== 8'h00 || obs_q[2] !== 8'h00) begin fails++; $display("FAIL empty_bytes: got %h %h %h want e5 00 00", obs_q[0], obs_q[1], obs_q[2]); end
    end
  endtask

  task automatic test_overflow();
    start_scenario();
    for (int i = 0; i < 10; i++) recs_q.push_back(23'(i));
    send_window(0);
    wait_done();
    tests++; if (timed_out) begin fails++; $display("FAIL ovf_timeout: busy %b want 0", out_busy); end
    tests++;
    if (obs_q.size() != 27) begin fails++; $display("FAIL ovf_len: got %0d want 27", obs_q.size()); end
    else begin
      tests++; if (obs_q[1] !== 8'h88) begin fails++; $display("FAIL ovf_cnt: got %h want 88", obs_q[1]); end
      tests++; if (obs_q[26] !== 8'hA4) begin fails++; $display("FAIL ovf_csum: got %h want a4", obs_q[26]); end
      tests++; if (obs_q[23] !== 8'h00 || obs_q[24] !== 8'h00 || obs_q[25] !== 8'h07) begin fails++; $display("FAIL ovf_rec7: got %h %h %h want 00 00 07", obs_q[23], obs_q[24], obs_q[25]); end
      foreach (exp_q[i]) begin
        tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    start_scenario();
    recs_q.push_back(23'h7F1234);
    send_window(1);
    tick();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_byte_valid !== 1'b1 || out_byte !== 8'h01) begin fails++; $display("FAIL bp_hold%0d: got valid %b byte %h want 1 01", i, out_byte_valid, out_byte); end
      tick();
    end
    ready = 1'b1;
    tick();
    tests++; if (out_byte !== 8'h7F) begin fails++; $display("FAIL bp_resume: got %h want 7f", out_byte); end
    wait_done();
    tests++;
    if (timed_out || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    start_scenario();
    recs_q.push_back(23'h2A5A5A);
    recs_q.push_back(23'h13C3C3);
    send_window(0);
    repeat (3) tick();
    tests++; if (out_byte !== 8'h5A) begin fails++; $display("FAIL rst_mid_pos: got %h want 5a", out_byte); end
    reset = 1'b1;
    tick();
    tests++; if (out_byte_valid !== 1'b0 || out_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_out: got valid %b busy %b want 0 0", out_byte_valid, out_busy); end
    reset = 1'b0;
    tick();
    start_scenario();
    recs_q.push_back(23'h0000F0);
    send_window(1);
    wait_done();
    tests++;
    if (timed_out || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_fresh_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rst_fresh_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    start_scenario();
    recs_q.push_back(23'h4ABCDE);
    recs_q.push_back(23'h001111);
    recs_q.push_back(23'h7FFFFF);
    send_window(0);
    repeat (3) tick();
    rec_in = 23'h555555; rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    tick();
    rec_in = 23'h666666; rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    wait_done();
    tests++; if (ovr_cnt !== 2) begin fails++; $display("FAIL ovr_pulses: got %0d want 2", ovr_cnt); end
    tests++;
    if (timed_out || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL ovr_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovr_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    start_scenario();
    recs_q.push_back(23'h123456);
    send_window(0);
    flush = 1'b1;
    while (out_busy && g < 100) begin tick(); g++; end
    recs_q.delete();
    recs_q.push_back(23'h65ABCD);
    build_exp();
    rec_in = 23'h65ABCD; rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    wait_done();
    tests++;
    if (timed_out || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_single();
    test_empty();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_overrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
